// File: rtl/muldiv_issue_queue_if.sv
// Dispatch, CDB and issue signals of the Mul_Div reservation station.
// master: the dispatch/CDB/writeback side; slave: the queue itself.
interface muldiv_issue_queue_if #(parameter int TAG_W = 6);
   logic             flush;
   logic             dispatch_valid;
   logic             dispatch_ready;
   logic [4:0]       dispatch_execute_type;
   logic [TAG_W-1:0] dispatch_rob_tag;
   logic [31:0]      src1_value;
   logic [TAG_W-1:0] src1_tag;
   logic             src1_ready;
   logic [31:0]      src2_value;
   logic [TAG_W-1:0] src2_tag;
   logic             src2_ready;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_value;
   logic             issue_valid;
   logic             issue_ready;
   logic [31:0]      issue_operand1;
   logic [31:0]      issue_operand2;
   logic [4:0]       issue_execute_type;
   logic [TAG_W-1:0] issue_rob_tag;

   modport master (
      output flush, dispatch_valid, dispatch_execute_type, dispatch_rob_tag,
             src1_value, src1_tag, src1_ready, src2_value, src2_tag, src2_ready,
             cdb_valid, cdb_tag, cdb_value, issue_ready,
      input  dispatch_ready, issue_valid, issue_operand1, issue_operand2,
             issue_execute_type, issue_rob_tag
   );

   modport slave (
      input  flush, dispatch_valid, dispatch_execute_type, dispatch_rob_tag,
             src1_value, src1_tag, src1_ready, src2_value, src2_tag, src2_ready,
             cdb_valid, cdb_tag, cdb_value, issue_ready,
      output dispatch_ready, issue_valid, issue_operand1, issue_operand2,
             issue_execute_type, issue_rob_tag
   );
endinterface

// File: rtl/muldiv_issue_queue.sv
// Collapsing reservation station in front of the combinational Mul_Div unit.
// Slot 0 is oldest; entries capture missing operands from the CDB and the
// oldest entry with both operands ready is presented for issue.
module muldiv_issue_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input logic                clk,
   input logic                rst,
   muldiv_issue_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   logic [CW-1:0]                count, count_n;
   logic [DEPTH-1:0][4:0]        e_type, e_type_n;
   logic [DEPTH-1:0][TAG_W-1:0]  e_rob, e_rob_n;
   logic [DEPTH-1:0][31:0]       s1_val, s1_val_n, s2_val, s2_val_n;
   logic [DEPTH-1:0][TAG_W-1:0]  s1_tag, s1_tag_n, s2_tag, s2_tag_n;
   logic [DEPTH-1:0]             s1_rdy, s1_rdy_n, s2_rdy, s2_rdy_n;
   logic [IW-1:0]                sel, wpos;
   logic                         found, dispatch_fire, issue_fire;
   logic                         byp1, byp2;

   assign bus.dispatch_ready     = (count < CW'(DEPTH));
   assign dispatch_fire          = bus.dispatch_valid && bus.dispatch_ready;
   assign issue_fire             = found && bus.issue_ready;
   assign wpos                   = IW'(count - CW'(issue_fire));
   assign byp1                   = !bus.src1_ready && bus.cdb_valid && (bus.cdb_tag == bus.src1_tag);
   assign byp2                   = !bus.src2_ready && bus.cdb_valid && (bus.cdb_tag == bus.src2_tag);

   assign bus.issue_valid        = found;
   assign bus.issue_operand1     = found ? s1_val[sel] : '0;
   assign bus.issue_operand2     = found ? s2_val[sel] : '0;
   assign bus.issue_execute_type = found ? e_type[sel] : '0;
   assign bus.issue_rob_tag      = found ? e_rob[sel]  : '0;

   // Oldest valid entry with both operands ready (scan from top so slot 0 wins).
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (CW'(i) < count && s1_rdy[i] && s2_rdy[i]) begin
            sel   = IW'(i);
            found = 1'b1;
         end
      end
   end

   // Next state: CDB wakeup, then collapse over the issued slot, then dispatch write.
   always_comb begin
      e_type_n = e_type;
      e_rob_n  = e_rob;
      s1_val_n = s1_val;
      s2_val_n = s2_val;
      s1_tag_n = s1_tag;
      s2_tag_n = s2_tag;
      s1_rdy_n = s1_rdy;
      s2_rdy_n = s2_rdy;
      count_n  = count + CW'(dispatch_fire) - CW'(issue_fire);

      // Wakeup is applied before shifting so values landing this edge move with their entry.
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.cdb_valid && CW'(i) < count) begin
            if (!s1_rdy[i] && s1_tag[i] == bus.cdb_tag) begin
               s1_val_n[i] = bus.cdb_value;
               s1_rdy_n[i] = 1'b1;
            end
            if (!s2_rdy[i] && s2_tag[i] == bus.cdb_tag) begin
               s2_val_n[i] = bus.cdb_value;
               s2_rdy_n[i] = 1'b1;
            end
         end
      end

      if (issue_fire) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (IW'(i) >= sel) begin
               e_type_n[i] = e_type_n[i+1];
               e_rob_n[i]  = e_rob_n[i+1];
               s1_val_n[i] = s1_val_n[i+1];
               s2_val_n[i] = s2_val_n[i+1];
               s1_tag_n[i] = s1_tag_n[i+1];
               s2_tag_n[i] = s2_tag_n[i+1];
               s1_rdy_n[i] = s1_rdy_n[i+1];
               s2_rdy_n[i] = s2_rdy_n[i+1];
            end
         end
         s1_rdy_n[DEPTH-1] = 1'b0;
         s2_rdy_n[DEPTH-1] = 1'b0;
      end

      if (dispatch_fire) begin
         e_type_n[wpos] = bus.dispatch_execute_type;
         e_rob_n[wpos]  = bus.dispatch_rob_tag;
         s1_tag_n[wpos] = bus.src1_tag;
         s2_tag_n[wpos] = bus.src2_tag;
         s1_val_n[wpos] = byp1 ? bus.cdb_value : bus.src1_value;
         s2_val_n[wpos] = byp2 ? bus.cdb_value : bus.src2_value;
         s1_rdy_n[wpos] = bus.src1_ready || byp1;
         s2_rdy_n[wpos] = bus.src2_ready || byp2;
      end
   end

   // State update; reset and flush both empty the queue and drop all ready bits.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         count  <= '0;
         s1_rdy <= '0;
         s2_rdy <= '0;
      end else begin
         count  <= count_n;
         e_type <= e_type_n;
         e_rob  <= e_rob_n;
         s1_val <= s1_val_n;
         s2_val <= s2_val_n;
         s1_tag <= s1_tag_n;
         s2_tag <= s2_tag_n;
         s1_rdy <= s1_rdy_n;
         s2_rdy <= s2_rdy_n;
      end
   end
endmodule

// File: tb/tb_muldiv_issue_queue.sv
// Directed, table-driven bench for muldiv_issue_queue (DEPTH=4, TAG_W=6).
// Each row holds the inputs for one cycle and the outputs expected during
// that cycle, i.e. before the edge that consumes the inputs.
module tb_muldiv_issue_queue;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_issue_queue_if #(.TAG_W(6)) bus();
   muldiv_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        rst, flush, dv;
      logic [4:0]  typ;
      logic [5:0]  rtag;
      logic [31:0] s1v;
      logic [5:0]  s1t;
      logic        s1r;
      logic [31:0] s2v;
      logic [5:0]  s2t;
      logic        s2r;
      logic        cv;
      logic [5:0]  ct;
      logic [31:0] cval;
      logic        ir;
      logic        chk;
      logic        edr, eiv;
      logic [31:0] eop1, eop2;
      logic [4:0]  etyp;
      logic [5:0]  etag;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t row(input logic ir, input logic edr, input logic eiv,
                                input logic [31:0] op1, input logic [31:0] op2,
                                input logic [4:0] typ, input logic [5:0] tag);
      vec_t r = '{default: 0};
      r.ir = ir; r.chk = 1'b1;
      r.edr = edr; r.eiv = eiv; r.eop1 = op1; r.eop2 = op2; r.etyp = typ; r.etag = tag;
      return r;
   endfunction

   function automatic vec_t disp(input vec_t r, input logic [4:0] typ, input logic [5:0] tag,
                                 input logic [31:0] v1, input logic [5:0] t1, input logic r1,
                                 input logic [31:0] v2, input logic [5:0] t2, input logic r2);
      r.dv = 1'b1; r.typ = typ; r.rtag = tag;
      r.s1v = v1; r.s1t = t1; r.s1r = r1;
      r.s2v = v2; r.s2t = t2; r.s2r = r2;
      return r;
   endfunction

   function automatic vec_t cdb(input vec_t r, input logic [5:0] tag, input logic [31:0] val);
      r.cv = 1'b1; r.ct = tag; r.cval = val;
      return r;
   endfunction

   function automatic vec_t ctl(input vec_t r, input logic rs, input logic fl);
      r.rst = rs; r.flush = fl;
      return r;
   endfunction

   task automatic apply(input vec_t r);
      rst                       = r.rst;
      bus.flush                 = r.flush;
      bus.dispatch_valid        = r.dv;
      bus.dispatch_execute_type = r.typ;
      bus.dispatch_rob_tag      = r.rtag;
      bus.src1_value            = r.s1v;
      bus.src1_tag              = r.s1t;
      bus.src1_ready            = r.s1r;
      bus.src2_value            = r.s2v;
      bus.src2_tag              = r.s2t;
      bus.src2_ready            = r.s2r;
      bus.cdb_valid             = r.cv;
      bus.cdb_tag               = r.ct;
      bus.cdb_value             = r.cval;
      bus.issue_ready           = r.ir;
   endtask

   task automatic check(input string nm, input logic edr, input logic eiv,
                        input logic [31:0] op1, input logic [31:0] op2,
                        input logic [4:0] typ, input logic [5:0] tag);
      logic [76:0] act, exp;
      act = {bus.dispatch_ready, bus.issue_valid, bus.issue_operand1, bus.issue_operand2,
             bus.issue_execute_type, bus.issue_rob_tag};
      exp = {edr, eiv, op1, op2, typ, tag};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got dr=%0b iv=%0b op1=%h op2=%h type=%0d tag=%0d, want dr=%0b iv=%0b op1=%h op2=%h type=%0d tag=%0d",
                  nm, bus.dispatch_ready, bus.issue_valid, bus.issue_operand1, bus.issue_operand2,
                  bus.issue_execute_type, bus.issue_rob_tag, edr, eiv, op1, op2, typ, tag);
      end
   endtask

   initial begin
      // reset, then reset-state check
      vq.push_back(ctl(row(0, 1, 0, 0, 0, 0, 0), 1, 0));
      vq[0].chk = 1'b0;
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));
      // simple MUL, issues next cycle, queue empties after
      vq.push_back(disp(row(1, 1, 0, 0, 0, 0, 0), 0, 3, 7, 0, 1, 6, 0, 1));
      vq.push_back(row(1, 1, 1, 7, 6, 0, 3));
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));
      // src2 waits on tag 9; CDB two cycles later
      vq.push_back(disp(row(1, 1, 0, 0, 0, 0, 0), 1, 5, 1, 0, 1, 0, 9, 0));
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));
      vq.push_back(cdb(row(1, 1, 0, 0, 0, 0, 0), 9, 32'h100));
      vq.push_back(row(1, 1, 1, 1, 32'h100, 1, 5));
      // dispatch-time bypass
      vq.push_back(cdb(disp(row(1, 1, 0, 0, 0, 0, 0), 2, 6, 2, 0, 1, 0, 10, 0), 10, 32'h55));
      vq.push_back(row(1, 1, 1, 2, 32'h55, 2, 6));
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));
      // A waits on tag 2, B and C ready: B issues, C shifts, then A, then C
      vq.push_back(disp(row(1, 1, 0, 0, 0, 0, 0), 3, 7, 32'h11, 2, 0, 32'h22, 0, 1));
      vq.push_back(disp(row(1, 1, 0, 0, 0, 0, 0), 4, 8, 32'h33, 0, 1, 32'h44, 0, 1));
      vq.push_back(disp(row(0, 1, 1, 32'h33, 32'h44, 4, 8), 5, 11, 32'h55, 0, 1, 32'h66, 0, 1));
      vq.push_back(cdb(row(1, 1, 1, 32'h33, 32'h44, 4, 8), 2, 32'hAA));
      vq.push_back(row(1, 1, 1, 32'hAA, 32'h22, 3, 7));
      vq.push_back(row(1, 1, 1, 32'h55, 32'h66, 5, 11));
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));
      // fill four entries under backpressure
      vq.push_back(disp(row(0, 1, 0, 0, 0, 0, 0), 1, 20, 20, 0, 1, 276, 0, 1));
      vq.push_back(disp(row(0, 1, 1, 20, 276, 1, 20), 1, 21, 21, 0, 1, 277, 0, 1));
      vq.push_back(disp(row(0, 1, 1, 20, 276, 1, 20), 1, 22, 22, 0, 1, 278, 0, 1));
      vq.push_back(disp(row(0, 1, 1, 20, 276, 1, 20), 1, 23, 23, 0, 1, 279, 0, 1));
      // full: fifth dispatch ignored, then issue+dispatch at full refuses the dispatch
      vq.push_back(disp(row(0, 0, 1, 20, 276, 1, 20), 1, 24, 24, 0, 1, 280, 0, 1));
      vq.push_back(disp(row(1, 0, 1, 20, 276, 1, 20), 1, 24, 24, 0, 1, 280, 0, 1));
      vq.push_back(disp(row(0, 1, 1, 21, 277, 1, 21), 1, 24, 24, 0, 1, 280, 0, 1));
      vq.push_back(row(0, 0, 1, 21, 277, 1, 21));
      vq.push_back(row(1, 0, 1, 21, 277, 1, 21));
      // count 3: dispatch + issue keeps count at 3
      vq.push_back(disp(row(1, 1, 1, 22, 278, 1, 22), 1, 25, 25, 0, 1, 281, 0, 1));
      // flush with dispatch and CDB hit in the same cycle
      vq.push_back(cdb(disp(ctl(row(0, 1, 1, 23, 279, 1, 23), 0, 1), 1, 26, 26, 0, 1, 282, 0, 1), 30, 32'h1234));
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));
      // mid-operation reset; stale CDB afterwards wakes nothing
      vq.push_back(disp(row(0, 1, 0, 0, 0, 0, 0), 2, 40, 1, 0, 1, 2, 0, 1));
      vq.push_back(disp(row(0, 1, 1, 1, 2, 2, 40), 3, 41, 0, 12, 0, 9, 0, 1));
      vq.push_back(ctl(row(0, 1, 1, 1, 2, 2, 40), 1, 0));
      vq.push_back(cdb(row(1, 1, 0, 0, 0, 0, 0), 12, 32'h99));
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));
      vq.push_back(disp(row(1, 1, 0, 0, 0, 0, 0), 4, 42, 3, 0, 1, 4, 0, 1));
      vq.push_back(row(1, 1, 1, 3, 4, 4, 42));
      vq.push_back(row(1, 1, 0, 0, 0, 0, 0));

      foreach (vq[i]) begin
         @(negedge clk);
         apply(vq[i]);
         #1;
         if (vq[i].chk)
            check($sformatf("row%0d", i), vq[i].edr, vq[i].eiv, vq[i].eop1, vq[i].eop2,
                  vq[i].etyp, vq[i].etag);
      end

      // One CDB broadcast wakes both sources of H and one source of I.
      @(negedge clk);
      apply(disp(row(1, 1, 0, 0, 0, 0, 0), 6, 50, 0, 13, 0, 0, 13, 0));
      @(negedge clk);
      apply(disp(row(1, 1, 0, 0, 0, 0, 0), 7, 51, 0, 13, 0, 5, 0, 1));
      #1 check("multi_wake_wait", 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      apply(cdb(row(1, 1, 0, 0, 0, 0, 0), 13, 32'h77));
      #1 check("multi_wake_pre", 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      apply(row(1, 1, 0, 0, 0, 0, 0));
      #1 check("multi_wake_h", 1, 1, 32'h77, 32'h77, 6, 50);
      @(negedge clk);
      #1 check("multi_wake_i", 1, 1, 32'h77, 5, 7, 51);
      @(negedge clk);
      #1 check("multi_wake_empty", 1, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_issue_queue.md
Name: muldiv_issue_queue

Overview:
- Reservation station directly upstream of the combinational Mul_Div functional unit in the superscalar RISC-V core.
- Buffers dispatched MUL/DIV micro-ops and captures missing source operands from the common data bus (CDB).
- Issues the oldest entry whose operands are both ready as {operand1, operand2, execute_type} plus its ROB tag.
- Mul_Div result is written back by the downstream stage.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 6, ROB/physical tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all entries (branch mispredict).
- dispatch_valid  in  1  dispatch offers a micro-op.
- dispatch_ready  out  1  queue can accept this cycle.
- dispatch_execute_type  in  5  Mul_Div operation code.
- dispatch_rob_tag  in  TAG_W  destination ROB tag.
- src1_value  in  32  operand1 value, valid when src1_ready=1.
- src1_tag  in  TAG_W  producer tag, used when src1_ready=0.
- src1_ready  in  1  operand1 already available.
- src2_value, src2_tag, src2_ready  in  32/TAG_W/1  same for operand2.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  32  broadcast value.
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  Mul_Div/writeback stage accepts.
- issue_operand1  out  32  to Mul_Div operand1.
- issue_operand2  out  32  to Mul_Div operand2.
- issue_execute_type  out  5  to Mul_Div execute_type.
- issue_rob_tag  out  TAG_W  tag travelling with the result.

Behaviour:
- Storage is a collapsing queue. Slot 0 is the oldest entry; a count register gives occupancy (0..DEPTH). Each slot holds type, rob_tag, and per-source {value, tag, rdy}.
- Reset or flush: count=0 and all entry rdy bits cleared. Reset takes priority over flush. Flush takes priority over dispatch and issue in the same cycle.
- Reset values of outputs: issue_valid=0, all issue_* data outputs = 0, dispatch_ready=1.
- dispatch_ready = (count < DEPTH). It does not look ahead at a same-cycle issue; a full queue refuses dispatch even while issuing.
- Dispatch handshake: fires when dispatch_valid && dispatch_ready. The new entry is written to slot count, or slot count-1 if an issue fires in the same cycle.
- Dispatch-time bypass: if src_ready=0, cdb_valid=1 and cdb_tag==src_tag, the entry stores cdb_value with rdy=1.
- Wakeup: every cycle, each valid entry with rdy=0 and tag==cdb_tag (cdb_valid=1) latches cdb_value and sets rdy=1 at the clock edge. One CDB value may wake several entries and both sources of one entry.
- Issue select is combinational from registered state. It picks the lowest-index slot with both rdy=1. A source woken at edge N is issuable in cycle N (the cycle after the broadcast); there is no same-cycle CDB-to-issue forwarding.
- issue_valid=1 when a selected entry exists. issue_* outputs show that entry; all are 0 when issue_valid=0.
- Issue handshake: fires when issue_valid && issue_ready. The selected slot is removed, slots above it shift down by one (preserving age order, including wakeups landing that edge), and count decrements.
- Backpressure: if issue_ready=0, outputs are held stable unless an older entry becomes ready. Selection always re-evaluates to the oldest ready entry.
- Simultaneous dispatch+issue at count=DEPTH-1: count stays DEPTH-1. At count=DEPTH the dispatch is refused and count becomes DEPTH-1.
- Out-of-order issue is permitted; age priority only breaks ties among ready entries.
- Mul_Div is single-cycle combinational, so the downstream stage normally holds issue_ready=1.

Test Plan:
- Reset then dispatch {type=0 MUL, tag=3, src1=7 rdy, src2=6 rdy} -> next cycle issue_valid=1, operand1=7, operand2=6, rob_tag=3; with issue_ready=1 the queue empties the following cycle.
- Dispatch tag=5 with src2 waiting on tag 9; CDB {9, 0x100} two cycles later -> issue_valid rises the cycle after the broadcast with operand2=0x100. A bypass variant (CDB on the dispatch cycle) issues the next cycle.
- Dispatch A (waiting on tag 2) then B (both ready) -> B issues first. After CDB tag 2, A issues, and its slot 0 entry shifts correctly once B leaves.
- Fill 4 entries with issue_ready=0 -> dispatch_ready=0 and a 5th dispatch is ignored. Raise issue_ready with a dispatch in the same cycle -> oldest issues, count stays at 4-1+0=3 (dispatch refused), then accepts.
- Queue with 3 entries, assert flush together with dispatch_valid and a CDB hit -> next cycle count=0, issue_valid=0, dispatch_ready=1.
- Assert rst mid-operation with issue_valid=1 -> next cycle all outputs at reset values; stale CDB tags broadcast afterwards wake nothing.
